// File: rtl/wb_arbiter_pkg.sv
// Shared constants and helpers for the writeback arbiter slice.
package wb_arbiter_pkg;

  localparam int unsigned WbNumReq     = 3;
  localparam int unsigned Xlen         = 64;
  localparam int unsigned RegAddrWidth = 5;

  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner on advance.
module rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = WbNumReq
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [PtrW-1:0]    sel;
  logic [NUM_REQ-1:0] upper;
  logic               any_upper;

  always_comb begin
    upper = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper[i] = req[i] && (PtrW'(i) >= ptr_q);
    end
    any_upper = |upper;
    sel = '0;
    // Lowest requester at/above the pointer wins, else wrap to lowest overall.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (any_upper ? upper[i] : req[i]) sel = PtrW'(i);
    end
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = (|req) && (sel == PtrW'(i));
    end
    ptr_d = ptr_q;
    if (advance && (|req)) ptr_d = PtrW'(rr_next(32'(sel), NUM_REQ));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin regfile write port plus pending-write scoreboard.
// Optional WB_BYPASS_EN adds forwarding of the registered write to hazard queries.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = WbNumReq,
  parameter int unsigned XLEN    = Xlen,
  parameter int unsigned AW      = RegAddrWidth
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic                    rd_wen,
  output logic [AW-1:0]           rd_addr,
  output logic [XLEN-1:0]         rd_data,
  input  logic                    sb_set,
  input  logic [AW-1:0]           sb_set_addr,
  input  logic [AW-1:0]           rs1_addr,
  input  logic [AW-1:0]           rs2_addr,
`ifdef WB_BYPASS_EN
  output logic                    rs1_fwd_hit,
  output logic                    rs2_fwd_hit,
  output logic [XLEN-1:0]         rs1_fwd_data,
  output logic [XLEN-1:0]         rs2_fwd_data,
`endif
  output logic                    rs1_busy,
  output logic                    rs2_busy
);

  localparam int unsigned NumRegs = 1 << AW;

  logic [NUM_REQ-1:0] grant;
  logic [AW-1:0]      win_addr;
  logic [XLEN-1:0]    win_data;
  logic               rd_wen_q;
  logic [AW-1:0]      rd_addr_q;
  logic [XLEN-1:0]    rd_data_q;
  logic [NumRegs-1:0] pend_q, pend_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (|req_valid),
    .grant   (grant)
  );

  // The output stage never stalls, so every grant is an accept.
  assign req_ready = grant;

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_addr = req_addr[i*AW +: AW];
        win_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0 are accepted but dropped; address/data then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wen_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else if ((|grant) && (win_addr != '0)) begin
      rd_wen_q  <= 1'b1;
      rd_addr_q <= win_addr;
      rd_data_q <= win_data;
    end else begin
      rd_wen_q  <= 1'b0;
    end
  end

  assign rd_wen  = rd_wen_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;

  // Set after clear: a same-edge set belongs to a newer producer.
  always_comb begin
    pend_d = pend_q;
    if (rd_wen_q) pend_d[rd_addr_q] = 1'b0;
    if (sb_set && (sb_set_addr != '0)) pend_d[sb_set_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

`ifdef WB_BYPASS_EN
  assign rs1_fwd_hit  = rd_wen_q && (rd_addr_q == rs1_addr) && (rs1_addr != '0);
  assign rs2_fwd_hit  = rd_wen_q && (rd_addr_q == rs2_addr) && (rs2_addr != '0);
  assign rs1_fwd_data = rd_data_q;
  assign rs2_fwd_data = rd_data_q;
  assign rs1_busy     = pend_q[rs1_addr] && !rs1_fwd_hit;
  assign rs2_busy     = pend_q[rs2_addr] && !rs2_fwd_hit;
`else
  assign rs1_busy     = pend_q[rs1_addr];
  assign rs2_busy     = pend_q[rs2_addr];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a queue/array-level reference model.
module tb_wb_arbiter;

  localparam int N    = 3;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*XLEN-1:0] req_data;
  logic              rd_wen;
  logic [AW-1:0]     rd_addr;
  logic [XLEN-1:0]   rd_data;
  logic              sb_set;
  logic [AW-1:0]     sb_set_addr;
  logic [AW-1:0]     rs1_addr;
  logic [AW-1:0]     rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;
`ifdef WB_BYPASS_EN
  logic              rs1_fwd_hit;
  logic              rs2_fwd_hit;
  logic [XLEN-1:0]   rs1_fwd_data;
  logic [XLEN-1:0]   rs2_fwd_data;
`endif

  always #5 clk = ~clk;

  wb_arbiter #(
    .NUM_REQ (N),
    .XLEN    (XLEN),
    .AW      (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .rd_wen       (rd_wen),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .sb_set       (sb_set),
    .sb_set_addr  (sb_set_addr),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
`ifdef WB_BYPASS_EN
    .rs1_fwd_hit  (rs1_fwd_hit),
    .rs2_fwd_hit  (rs2_fwd_hit),
    .rs1_fwd_data (rs1_fwd_data),
    .rs2_fwd_data (rs2_fwd_data),
`endif
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int              m_ptr;
  bit              m_pend[32];
  bit              m_wen;
  int              m_addr;
  logic [XLEN-1:0] m_data;

  // Requester-side view
  logic            v[N];
  logic [AW-1:0]   a[N];
  logic [XLEN-1:0] d[N];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]              = v[i];
      req_addr[i*AW +: AW]      = a[i];
      req_data[i*XLEN +: XLEN]  = d[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_wen = 0;
    m_addr = 0;
    m_data = '0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
  endtask

  function automatic int exp_grant();
    for (int off = 0; off < N; off++) begin
      if (v[(m_ptr + off) % N]) return (m_ptr + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r = '0;
    int g = exp_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic bit exp_busy(int rs);
    bit b = m_pend[rs];
`ifdef WB_BYPASS_EN
    if (m_wen && m_addr == rs && rs != 0) b = 0;
`endif
    return b;
  endfunction

  // Advance model and DUT by one clock; g is the requester accepted this cycle.
  task automatic tick(output int g);
    g = exp_grant();
    if (m_wen) m_pend[m_addr] = 0;
    if (sb_set && sb_set_addr != 0) m_pend[sb_set_addr] = 1;
    if (g >= 0) begin
      m_wen = (a[g] != 0);
      if (a[g] != 0) begin
        m_addr = a[g];
        m_data = d[g];
      end
      m_ptr = (g + 1) % N;
    end else begin
      m_wen = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      v[i] = 0;
      a[i] = '0;
      d[i] = '0;
    end
    sb_set = 0;
    sb_set_addr = '0;
    rs1_addr = '0;
    rs2_addr = '0;
    drive();
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    rs1_addr = 7;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd_wen !== 1'b0) begin
      failures++; $display("FAIL reset_rd_wen got=%0b want=0", rd_wen);
    end
    checks++;
    if (rd_addr !== '0 || rd_data !== '0) begin
      failures++; $display("FAIL reset_rd_addr_data got=%0d/%0h want=0/0", rd_addr, rd_data);
    end
    checks++;
    if (rs1_busy !== 1'b0 || req_ready !== '0) begin
      failures++; $display("FAIL reset_busy_ready got=%0b/%b want=0/000", rs1_busy, req_ready);
    end
    rst_n = 1;
  endtask

  task automatic test_single();
    int g;
    v[1] = 1; a[1] = 5; d[1] = 64'h1234;
    drive();
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      failures++; $display("FAIL single_ready got=%b want=010", req_ready);
    end
    tick(g);
    v[1] = 0;
    drive();
    checks++;
    if (rd_wen !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 64'h1234) begin
      failures++;
      $display("FAIL single_write got=%0b/%0d/%0h want=1/5/1234", rd_wen, rd_addr, rd_data);
    end
    tick(g);
    checks++;
    if (rd_wen !== 1'b0 || rd_addr !== 5'd5) begin
      failures++; $display("FAIL single_idle got=%0b/%0d want=0/5", rd_wen, rd_addr);
    end
  endtask

  task automatic test_rotate();
    int g;
    int cnt[N];
    int next_addr = 10;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      v[i] = 1; a[i] = AW'(next_addr); d[i] = 64'(next_addr) * 64'h101; next_addr++;
    end
    drive();
    for (int c = 0; c < 2 * N; c++) begin
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        failures++; $display("FAIL rotate_ready cyc=%0d got=%b want=%b", c, req_ready, exp_ready());
      end
      tick(g);
      if (g >= 0) cnt[g]++;
      checks++;
      if (rd_wen !== 1'b1 || rd_addr !== AW'(m_addr) || rd_data !== m_data) begin
        failures++;
        $display("FAIL rotate_write cyc=%0d got=%0d/%0h want=%0d/%0h", c, rd_addr, rd_data,
                 m_addr, m_data);
      end
      if (g >= 0) begin
        a[g] = AW'(next_addr); d[g] = 64'(next_addr) * 64'h101; next_addr++;
      end
      drive();
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cnt[i] != 2) begin
        failures++; $display("FAIL rotate_fairness req=%0d got=%0d want=2", i, cnt[i]);
      end
    end
    for (int i = 0; i < N; i++) v[i] = 0;
    drive();
    tick(g);
  endtask

  task automatic test_scoreboard();
    int g;
    sb_set = 1; sb_set_addr = 7;
    tick(g);
    sb_set = 0;
    rs1_addr = 7;
    #1;
    checks++;
    if (rs1_busy !== 1'b1) begin
      failures++; $display("FAIL sb_set_busy got=%0b want=1", rs1_busy);
    end
    v[0] = 1; a[0] = 7; d[0] = 64'hCAFE_0007;
    drive();
    tick(g);
    v[0] = 0;
    drive();
    checks++;
`ifdef WB_BYPASS_EN
    if (rs1_busy !== 1'b0 || rs1_fwd_hit !== 1'b1 || rs1_fwd_data !== 64'hCAFE_0007) begin
      failures++;
      $display("FAIL sb_fwd got=%0b/%0b/%0h want=0/1/cafe0007", rs1_busy, rs1_fwd_hit,
               rs1_fwd_data);
    end
`else
    if (rs1_busy !== 1'b1 || rd_wen !== 1'b1) begin
      failures++; $display("FAIL sb_commit_cycle got=%0b/%0b want=1/1", rs1_busy, rd_wen);
    end
`endif
    tick(g);
    checks++;
    if (rs1_busy !== 1'b0) begin
      failures++; $display("FAIL sb_cleared got=%0b want=0", rs1_busy);
    end
  endtask

  task automatic test_same_edge();
    int g;
    sb_set = 1; sb_set_addr = 9;
    tick(g);
    sb_set = 0;
    v[2] = 1; a[2] = 9; d[2] = 64'h99;
    drive();
    tick(g);
    v[2] = 0;
    drive();
    sb_set = 1; sb_set_addr = 9;
    rs2_addr = 9;
    tick(g);
    sb_set = 0;
    #1;
    checks++;
    if (rs2_busy !== 1'b1 || rs2_busy !== exp_busy(9)) begin
      failures++; $display("FAIL same_edge_set_wins got=%0b want=1", rs2_busy);
    end
    tick(g);
    checks++;
    if (rs2_busy !== 1'b1) begin
      failures++; $display("FAIL same_edge_hold got=%0b want=1", rs2_busy);
    end
  endtask

  task automatic test_addr_zero();
    int g;
    v[1] = 1; a[1] = 0; d[1] = 64'hFFFF;
    rs1_addr = 0;
    drive();
    #1;
    checks++;
    if (req_ready !== exp_ready() || req_ready === '0) begin
      failures++; $display("FAIL zero_ready got=%b want=%b", req_ready, exp_ready());
    end
    sb_set = 1; sb_set_addr = 0;
    tick(g);
    v[1] = 0; sb_set = 0;
    drive();
    checks++;
    if (rd_wen !== 1'b0) begin
      failures++; $display("FAIL zero_dropped got=%0b want=0", rd_wen);
    end
    checks++;
    if (rs1_busy !== 1'b0) begin
      failures++; $display("FAIL zero_busy got=%0b want=0", rs1_busy);
    end
  endtask

  task automatic test_random();
    int g;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1;
          a[i] = AW'($urandom_range(0, 31));
          d[i] = {$urandom, $urandom};
        end
      end
      sb_set = ($urandom_range(0, 2) == 0);
      sb_set_addr = AW'($urandom_range(0, 31));
      rs1_addr = AW'($urandom_range(0, 31));
      rs2_addr = (c % 4 == 0) ? AW'(m_addr) : AW'($urandom_range(0, 31));
      drive();
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, req_ready, exp_ready());
      end
      checks++;
      if (rs1_busy !== exp_busy(int'(rs1_addr)) || rs2_busy !== exp_busy(int'(rs2_addr))) begin
        failures++;
        $display("FAIL rand_busy cyc=%0d got=%0b%0b want=%0b%0b", c, rs1_busy, rs2_busy,
                 exp_busy(int'(rs1_addr)), exp_busy(int'(rs2_addr)));
      end
      tick(g);
      if (g >= 0) v[g] = 0;
      checks++;
      if (rd_wen !== m_wen || (m_wen && (rd_addr !== AW'(m_addr) || rd_data !== m_data))) begin
        failures++;
        $display("FAIL rand_write cyc=%0d got=%0b/%0d/%0h want=%0b/%0d/%0h", c, rd_wen, rd_addr,
                 rd_data, m_wen, m_addr, m_data);
      end
    end
    sb_set = 0;
  endtask

  task automatic test_mid_reset();
    int g;
    clear_inputs();
    sb_set = 1; sb_set_addr = 3;
    tick(g);
    sb_set_addr = 4;
    v[1] = 1; a[1] = 12; d[1] = 64'h12;
    drive();
    tick(g);
    sb_set = 0; v[1] = 0;
    rs1_addr = 3; rs2_addr = 4;
    drive();
    #2;
    checks++;
    if (rd_wen !== 1'b1 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre got=%0b/%0b/%0b want=1/1/1", rd_wen, rs1_busy, rs2_busy);
    end
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (rd_wen !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async got=%0b/%0b/%0b want=0/0/0", rd_wen, rs1_busy, rs2_busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < N; i++) begin
      v[i] = 1; a[i] = AW'(20 + i); d[i] = 64'(i);
    end
    drive();
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      failures++; $display("FAIL midrst_first_grant got=%b want=001", req_ready);
    end
    tick(g);
    checks++;
    if (rd_wen !== 1'b1 || rd_addr !== 5'd20) begin
      failures++; $display("FAIL midrst_first_write got=%0b/%0d want=1/20", rd_wen, rd_addr);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_scoreboard();
    test_same_edge();
    test_addr_zero();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single regfile write port between NUM_REQ writeback sources (ALU, load unit, mul/div), using round-robin arbitration.
- Registers the winning write onto the regfile write port (rd_wen/rd_addr/rd_data).
- Keeps a pending-write scoreboard: issue marks a destination busy, and commit of that write clears it.
- Issue logic queries the scoreboard for rs1/rs2 hazards and stalls on busy.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- XLEN, 64, data width; matches `XLEN.
- AW, 5, register address width; matches `REG_ADDR_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester grant/accept
- req_addr  in  NUM_REQ*AW  flattened destination addresses; requester i at [i*AW +: AW]
- req_data  in  NUM_REQ*XLEN  flattened write data; requester i at [i*XLEN +: XLEN]
- rd_wen  out  1  regfile write enable (registered)
- rd_addr  out  AW  regfile write address (registered)
- rd_data  out  XLEN  regfile write data (registered)
- sb_set  in  1  issue marks a destination pending
- sb_set_addr  in  AW  destination being marked
- rs1_addr  in  AW  hazard query address 1
- rs2_addr  in  AW  hazard query address 2
- rs1_busy  out  1  rs1_addr has a pending write (combinational)
- rs2_busy  out  1  rs2_addr has a pending write (combinational)

Behaviour:
- Reset (async, rst_n low):
  - rd_wen=0, rd_addr=0, rd_data=0.
  - Round-robin pointer = 0.
  - All pending bits = 0.
  - Any in-flight write is discarded.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - Requesters hold valid, addr and data stable until accepted.
  - req_ready is combinational from req_valid and the pointer. It is one-hot or zero, and nonzero whenever any valid is high.
- Arbitration:
  - Search starts at pointer p and proceeds upward, modulo NUM_REQ; the first valid requester wins.
  - After a grant to i, p <= (i+1) mod NUM_REQ.
  - With no grant, p holds.
- Output stage: never stalls, so throughput is one write per cycle.
  - Grant in cycle t: cycle t+1 has rd_wen=1, rd_addr/rd_data = winner's values. The regfile updates at the end of t+1.
  - No grant in t: rd_wen=0 in t+1; rd_addr/rd_data hold their previous values.
  - A granted request with addr 0 is accepted (ready=1), but rd_wen=0 the next cycle (write dropped).
- Scoreboard (32 bits, bit 0 forced 0):
  - Set: on a clk edge with sb_set && sb_set_addr!=0, pend[sb_set_addr] <= 1.
  - Clear: on the edge where rd_wen=1, pend[rd_addr] <= 0. This is the same edge the regfile commits.
  - Set and clear of the same address on the same edge: set wins, because it represents a newer producer.
  - rsN_busy = pend[rsN_addr]; always 0 for address 0.
- Boundaries:
  - All requesters valid every cycle: grants rotate 0,1,2,0,…, with no starvation. Worst-case wait is NUM_REQ-1 cycles.
  - A single requester continuously valid is granted every cycle.
  - A write commit without a prior set simply leaves the pend bit at 0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs rs1_fwd_hit, rs2_fwd_hit (1 bit each) and rs1_fwd_data, rs2_fwd_data (XLEN each).
  - rsN_fwd_hit = rd_wen && rd_addr==rsN_addr && rsN_addr!=0.
  - rsN_fwd_data = rd_data.
  - rsN_busy is masked to 0 when rsN_fwd_hit, so dependents issue one cycle earlier.
- Undefined: these ports are absent, and busy clears only after the regfile commit edge.

Decomposition:
- defines.v gains `WB_NUM_REQ (default 3), alongside the existing `XLEN and `REG_ADDR_WIDTH.
- One sub-module: rr_arbiter (NUM_REQ parameter).
  - Inputs: req vector, advance.
  - Outputs: one-hot grant.
  - Holds the pointer internally, with the same reset behaviour.
- The scoreboard and output register stay in wb_arbiter.

Test Plan:
- Reset, then requester 1 valid with addr 5, data 0x1234 → req_ready=3'b010 in the same cycle; next cycle rd_wen=1, rd_addr=5, rd_data=0x1234; then rd_wen=0.
- All 3 requesters valid for 6 cycles with distinct addrs → grants 0,1,2,0,1,2; rd_addr sequence matches one cycle later.
- sb_set addr 7 → rs1_addr=7 gives rs1_busy=1; writeback of x7 → busy stays 1 during the rd_wen cycle and is 0 the cycle after (macro undefined). With WB_BYPASS_EN, fwd_hit=1 and busy=0 in the rd_wen cycle.
- Same edge: sb_set addr 9 while rd_wen=1, rd_addr=9 → rs2_busy=1 afterwards.
- Request with addr 0, data 0xFFFF → ready=1, next cycle rd_wen=0; rs1_addr=0 always gives busy=0; sb_set addr 0 is ignored.
- Assert rst_n low mid-burst with pend bits set and rd_wen=1 → immediately rd_wen=0, all busy=0; after release, the first grant goes to requester 0 when all requesters are valid.
